bell_judge_arbiter: RTL

//  N-player bell-press arbiter, judge and score register file for the card-bell game.
//  - Latches a round's face-up cards and grants the first bell press.
//  - Judges the press: correct when any colour's visible card numbers sum to TARGET.
//  - Updates saturating signed per-player scores and flags a leader by WIN_MARGIN.
//  - Sits between keypad/bell debouncers and the LCD/score display logic.

---
 rtl/bell_judge_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/bell_judge_arbiter.sv
// bell_judge_arbiter
// Bell-press arbiter, judge and score register file for the card-bell game.
// A round's face-up cards are snapshotted on round_start. The first bell press
// (rising edge) in ARMED is granted, with the lowest index winning ties. The
// press is judged correct when any colour's visible card numbers sum to TARGET.
// Per-player signed scores saturate, and a leader is flagged by WIN_MARGIN.
//
// Optional feature macro: BELL_TIMEOUT_EN. When it is defined, ARMED resolves
// after TIMEOUT_CYC press-free cycles with no winner and no score change.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   round_start     pulse: card_vis/card_color/card_num/pot_count valid
//   card_vis        per-player face-up flag
//   card_color      per-player colour, slice i = player i
//   card_num        per-player card number, slice i = player i
//   pot_count       points awarded for a correct press
//   bell            debounced bell levels
//   busy            high while in JUDGE and UPDATE
//   result_valid    one-cycle pulse when a round resolves
//   result_right    judgement of the last resolved round
//   result_winner   one-hot granted presser of the last round (0 on timeout)
//   score           signed scores, slice i = player i
//   win_sig         one-hot leader flag, registered from score
module bell_judge_arbiter #(
  parameter int N_PLAYERS   = 4,
  parameter int COLOR_W     = 2,
  parameter int CARD_W      = 3,
  parameter int TARGET      = 5,
  parameter int SCORE_W     = 9,
  parameter int PENALTY     = 1,
  parameter int WIN_MARGIN  = 50,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         round_start,
  input  logic [N_PLAYERS-1:0]         card_vis,
  input  logic [N_PLAYERS*COLOR_W-1:0] card_color,
  input  logic [N_PLAYERS*CARD_W-1:0]  card_num,
  input  logic [7:0]                   pot_count,
  input  logic [N_PLAYERS-1:0]         bell,
  output logic                         busy,
  output logic                         result_valid,
  output logic                         result_right,
  output logic [N_PLAYERS-1:0]         result_winner,
  output logic [N_PLAYERS*SCORE_W-1:0] score,
  output logic [N_PLAYERS-1:0]         win_sig
);

  localparam int NCOL  = 1 << COLOR_W;
  localparam int SUM_W = CARD_W + $clog2(N_PLAYERS) + 1;
  localparam int SMAX  = (1 << (SCORE_W - 1)) - 1;
  localparam int SMIN  = -(1 << (SCORE_W - 1));
  localparam logic signed [SCORE_W:0] MARGIN = (SCORE_W + 1)'(WIN_MARGIN);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_JUDGE, S_UPDATE, S_LOCK} state_t;

  state_t                       state;
  logic [N_PLAYERS-1:0]         bell_q;
  logic [N_PLAYERS-1:0]         vis_q;
  logic [N_PLAYERS*COLOR_W-1:0] color_q;
  logic [N_PLAYERS*CARD_W-1:0]  num_q;
  logic [7:0]                   pot_q;
  logic [N_PLAYERS-1:0]         grant;
  logic                         right_q;
  logic signed [SCORE_W-1:0]    sc [N_PLAYERS];

  logic [N_PLAYERS-1:0]         press;
  logic [N_PLAYERS-1:0]         grant_c;
  logic                         right_c;
  logic [SUM_W-1:0]             sum;
  logic [N_PLAYERS-1:0]         lead_c;
  logic signed [SCORE_W:0]      ext [N_PLAYERS];
  logic signed [SCORE_W:0]      thr;

`ifdef BELL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;
`else
  // Timeout is not built; the flag is constant low whatever TIMEOUT_CYC is.
  logic tmo_q;
  assign tmo_q = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  function automatic logic signed [SCORE_W-1:0] sat(input int v);
    if (v > SMAX)      return SCORE_W'(SMAX);
    else if (v < SMIN) return SCORE_W'(SMIN);
    else               return SCORE_W'(v);
  endfunction

  // Rising edges only; x & -x keeps the lowest set bit.
  assign press   = bell & ~bell_q;
  assign grant_c = press & (~press + N_PLAYERS'(1));

  always_comb begin
    right_c = 1'b0;
    sum     = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      sum = '0;
      for (int unsigned i = 0; i < N_PLAYERS; i++)
        if (vis_q[i] && color_q[i*COLOR_W +: COLOR_W] == COLOR_W'(c))
          sum = sum + SUM_W'(num_q[i*CARD_W +: CARD_W]);
      if (sum == SUM_W'(TARGET)) right_c = 1'b1;
    end
  end

  always_comb begin
    lead_c = '0;
    thr    = '0;
    for (int unsigned i = 0; i < N_PLAYERS; i++)
      ext[i] = {sc[i][SCORE_W-1], sc[i]};
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      lead_c[i] = 1'b1;
      for (int unsigned j = 0; j < N_PLAYERS; j++)
        if (j != i) begin
          thr = ext[j] + MARGIN;
          if (!(ext[i] > thr)) lead_c[i] = 1'b0;
        end
    end
  end

  always_comb begin
    score = '0;
    for (int unsigned i = 0; i < N_PLAYERS; i++)
      score[i*SCORE_W +: SCORE_W] = sc[i];
  end

  always_ff @(posedge clk) begin
    bell_q <= bell;
    if (!rst) begin
      state         <= S_IDLE;
      bell_q        <= '0;
      vis_q         <= '0;
      color_q       <= '0;
      num_q         <= '0;
      pot_q         <= '0;
      grant         <= '0;
      right_q       <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_right  <= 1'b0;
      result_winner <= '0;
      win_sig       <= '0;
      for (int unsigned i = 0; i < N_PLAYERS; i++) sc[i] <= '0;
`ifdef BELL_TIMEOUT_EN
      tmo_cnt       <= '0;
      tmo_q         <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      win_sig      <= lead_c;
      case (state)
        S_IDLE, S_LOCK, S_ARMED: begin
          if (round_start) begin
            vis_q   <= card_vis;
            color_q <= card_color;
            num_q   <= card_num;
            pot_q   <= pot_count;
            state   <= S_ARMED;
`ifdef BELL_TIMEOUT_EN
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
`endif
          end else if (state == S_ARMED) begin
            if (|press) begin
              grant <= grant_c;
              busy  <= 1'b1;
              state <= S_JUDGE;
            end
`ifdef BELL_TIMEOUT_EN
            else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
              tmo_q <= 1'b1;
              busy  <= 1'b1;
              state <= S_UPDATE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
`endif
          end
        end
        S_JUDGE: begin
          right_q <= right_c;
          state   <= S_UPDATE;
        end
        S_UPDATE: begin
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= S_LOCK;
          if (tmo_q) begin
            result_right  <= 1'b0;
            result_winner <= '0;
          end else begin
            result_right  <= right_q;
            result_winner <= grant;
            for (int unsigned i = 0; i < N_PLAYERS; i++) begin
              if (grant[i])
                sc[i] <= sat(int'(sc[i]) +
                             (right_q ? int'(pot_q) : -PENALTY * (N_PLAYERS - 1)));
              else if (!right_q)
                sc[i] <= sat(int'(sc[i]) + PENALTY);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
